// File: rtl/vector_shift_sequencer.sv
// rtl/vector_shift_sequencer.sv - chunked issue controller for the vector shift unit
//
// Purpose: accepts one vector shift instruction at a time, walks vs1/vs2 through
// the vector register file in 128-bit chunks, feeds each chunk pair to the
// combinational shift unit, captures the result and writes it back with byte
// enables that cover only the active bytes (vl clamped to VLEN/SEW).
//
// Ports:
//   clk_i, rsn_i                 clock, asynchronous active-low reset
//   req_*                        instruction request (valid/ready handshake)
//   rf_rd_*                      register-file read port (data one cycle after en)
//   su_*                         shift-unit control/operands and result
//   wb_*                         chunk writeback (valid/ready handshake)
//   done_o                       one-cycle pulse after the instruction retires

module vector_shift_sequencer #(
    parameter  int VLEN   = 512,
    localparam int NCHUNK = VLEN / 128,
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int VLW    = $clog2(VLEN / 8) + 1
) (
    input  logic            clk_i,
    input  logic            rsn_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_shift_type_i,
    input  logic [2:0]      req_vsew_i,
    input  logic [VLW-1:0]  req_vl_i,
    input  logic [4:0]      req_vs1_addr_i,
    input  logic [4:0]      req_vs2_addr_i,
    input  logic [4:0]      req_vd_addr_i,

    output logic            rf_rd_en_o,
    output logic [4:0]      rf_rd_addr1_o,
    output logic [4:0]      rf_rd_addr2_o,
    output logic [CW-1:0]   rf_rd_chunk_o,
    input  logic [127:0]    rf_rd_data1_i,
    input  logic [127:0]    rf_rd_data2_i,

    output logic            su_chip_enable_o,
    output logic [1:0]      su_shift_type_o,
    output logic [2:0]      su_vsew_o,
    output logic [127:0]    su_vs1_o,
    output logic [127:0]    su_vs2_o,
    input  logic [127:0]    su_vd_i,

    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_addr_o,
    output logic [CW-1:0]   wb_chunk_o,
    output logic [127:0]    wb_data_o,
    output logic [15:0]     wb_be_o,

    output logic            done_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    logic [2:0]     state_q;
    logic [1:0]     type_q;
    logic [2:0]     vsew_q;
    logic [4:0]     vs1_q;
    logic [4:0]     vs2_q;
    logic [4:0]     vd_q;
    logic [CW-1:0]  k_q;
    logic [CW-1:0]  last_q;
    logic [VLW-1:0] tb_q;
    logic [127:0]   op1_q;
    logic [127:0]   op2_q;
    logic [127:0]   wb_data_q;
    logic [15:0]    wb_be_q;
    logic           done_q;

    logic [VLW-1:0] vlmax;
    logic [VLW-1:0] vl_clamped;
    logic [VLW-1:0] tb_calc;
    logic [CW-1:0]  last_calc;
    logic           req_null;
    logic [15:0]    be_calc;

    // Request decode. Only evaluated for legal SEW; reserved SEW and vl==0
    // retire without touching the register file.
    always_comb begin
        vlmax      = VLW'(VLEN / 8) >> req_vsew_i[1:0];
        vl_clamped = (req_vl_i > vlmax) ? vlmax : req_vl_i;
        tb_calc    = vl_clamped << req_vsew_i[1:0];
        // ceil(TB/16)-1 == floor((TB-1)/16) whenever TB >= 1
        last_calc  = CW'((tb_calc - VLW'(1)) >> 4);
        req_null   = (req_vl_i == '0) || req_vsew_i[2];
    end

    // Byte b of chunk k is live when its absolute byte index is below TB.
    always_comb begin
        be_calc = '0;
        for (int b = 0; b < 16; b++) begin
            be_calc[b] = (VLW'({k_q, 4'(b)}) < tb_q);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            vsew_q    <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            k_q       <= '0;
            last_q    <= '0;
            tb_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            wb_data_q <= '0;
            wb_be_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        type_q <= req_shift_type_i;
                        vsew_q <= req_vsew_i;
                        vs1_q  <= req_vs1_addr_i;
                        vs2_q  <= req_vs2_addr_i;
                        vd_q   <= req_vd_addr_i;
                        k_q    <= '0;
                        if (req_null) begin
                            done_q <= 1'b1;
                        end else begin
                            tb_q    <= tb_calc;
                            last_q  <= last_calc;
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    op1_q   <= rf_rd_data1_i;
                    op2_q   <= rf_rd_data2_i;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    wb_data_q <= su_vd_i;
                    wb_be_q   <= be_calc;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    // Writeback payload holds until the consumer takes it.
                    if (wb_ready_i) begin
                        if (k_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            k_q     <= k_q + CW'(1);
                            state_q <= S_READ;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o      = (state_q == S_IDLE);
    assign rf_rd_en_o       = (state_q == S_READ);
    assign rf_rd_addr1_o    = vs1_q;
    assign rf_rd_addr2_o    = vs2_q;
    assign rf_rd_chunk_o    = k_q;
    assign su_chip_enable_o = (state_q == S_SHIFT);
    assign su_shift_type_o  = type_q;
    assign su_vsew_o        = vsew_q;
    assign su_vs1_o         = op1_q;
    assign su_vs2_o         = op2_q;
    assign wb_valid_o       = (state_q == S_WB);
    assign wb_addr_o        = vd_q;
    assign wb_chunk_o       = k_q;
    assign wb_data_o        = wb_data_q;
    assign wb_be_o          = wb_be_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_vector_shift_sequencer.sv
// tb/tb_vector_shift_sequencer.sv - self-checking bench for vector_shift_sequencer

module tb_vector_shift_sequencer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_type;
    logic [2:0]     req_vsew;
    logic [6:0]     req_vl;
    logic [4:0]     req_vs1, req_vs2, req_vd;
    logic           rf_rd_en;
    logic [4:0]     rf_rd_addr1, rf_rd_addr2;
    logic [1:0]     rf_rd_chunk;
    logic [127:0]   rd1, rd2;
    logic           su_ce;
    logic [1:0]     su_type;
    logic [2:0]     su_vsew;
    logic [127:0]   su_vs1, su_vs2, su_vd;
    logic           wb_valid;
    logic           wb_ready;
    logic [4:0]     wb_addr;
    logic [1:0]     wb_chunk;
    logic [127:0]   wb_data;
    logic [15:0]    wb_be;
    logic           done;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vector_shift_sequencer dut (
        .clk_i(clk), .rsn_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_shift_type_i(req_type), .req_vsew_i(req_vsew), .req_vl_i(req_vl),
        .req_vs1_addr_i(req_vs1), .req_vs2_addr_i(req_vs2), .req_vd_addr_i(req_vd),
        .rf_rd_en_o(rf_rd_en), .rf_rd_addr1_o(rf_rd_addr1), .rf_rd_addr2_o(rf_rd_addr2),
        .rf_rd_chunk_o(rf_rd_chunk), .rf_rd_data1_i(rd1), .rf_rd_data2_i(rd2),
        .su_chip_enable_o(su_ce), .su_shift_type_o(su_type), .su_vsew_o(su_vsew),
        .su_vs1_o(su_vs1), .su_vs2_o(su_vs2), .su_vd_i(su_vd),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr),
        .wb_chunk_o(wb_chunk), .wb_data_o(wb_data), .wb_be_o(wb_be),
        .done_o(done)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register file contents: a fixed hash of (register, chunk).
    function automatic logic [127:0] rf_word(input int r, input int c);
        logic [127:0] v;
        logic [31:0]  x;
        v = '0;
        for (int w = 0; w < 4; w++) begin
            x = 32'(r * 1103 + c * 97 + w * 13 + 5) * 32'h9E3779B9;
            x = x ^ (x >> 15);
            v[w*32 +: 32] = x;
        end
        return v;
    endfunction

    // Element-wise shift: vs2 element shifted by the low log2(SEW) bits of vs1.
    function automatic logic [127:0] shift_ref(input logic [127:0] a, input logic [127:0] b,
                                               input logic [1:0] t, input logic [2:0] sew);
        logic [127:0] r;
        logic [63:0]  ev, av, res, mask;
        int w, amt;
        r = '0;
        if (sew > 3'd3 || t == 2'd0) return '0;
        w = 8 << sew;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int e = 0; e < 128 / w; e++) begin
            ev  = 64'(b >> (e * w)) & mask;
            av  = 64'(a >> (e * w));
            amt = int'(av[5:0]) & (w - 1);
            case (t)
                2'd1:    res = ev << amt;
                2'd2:    res = ev >> amt;
                default: begin
                    if (ev[w-1]) ev = ev | ~mask;
                    res = 64'($signed(ev) >>> amt);
                end
            endcase
            r = r | (128'(res & mask) << (e * w));
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rf_rd_en) begin
            rd1 <= rf_word(int'(rf_rd_addr1), int'(rf_rd_chunk));
            rd2 <= rf_word(int'(rf_rd_addr2), int'(rf_rd_chunk));
        end
    end

    always_comb begin
        su_vd = '0;
        if (su_ce) su_vd = shift_ref(su_vs1, su_vs2, su_type, su_vsew);
    end

    typedef struct {
        logic [4:0]   addr;
        logic [1:0]   chunk;
        logic [15:0]  be;
        logic [127:0] data;
    } beat_t;

    beat_t       expq[$];
    logic [15:0] hs_be[$];
    logic [1:0]  hs_chunk[$];
    int          rd_cnt = 0;
    int          exp_done = -1;

    // Expected writebacks for one instruction, straight from the byte arithmetic.
    function automatic int build_model(input logic [1:0] t, input logic [2:0] sew, input int vl,
                                       input int vs1, input int vs2, input int vd);
        int vlmax, vlc, tb, n, rem;
        beat_t bt;
        if (vl == 0 || sew > 3'd3) return 0;
        vlmax = 64 >> sew;
        vlc   = (vl > vlmax) ? vlmax : vl;
        tb    = vlc << sew;
        n     = (tb + 15) / 16;
        for (int c = 0; c < n; c++) begin
            rem      = tb - 16 * c;
            bt.addr  = 5'(vd);
            bt.chunk = 2'(c);
            bt.be    = (rem >= 16) ? 16'hFFFF : 16'((32'd1 << rem) - 32'd1);
            bt.data  = shift_ref(rf_word(vs1, c), rf_word(vs2, c), t, sew);
            expq.push_back(bt);
        end
        return n;
    endfunction

    always @(negedge clk) begin
        beat_t h;
        int n;
        if (!rst_n) begin
            expq.delete();
            exp_done = -1;
        end else begin
            if (done || cyc == exp_done) begin
                chk("done_pulse", 160'(done), 160'(1));
                chk("done_cycle", 160'(cyc), 160'(exp_done));
                exp_done = -1;
            end
            if (rf_rd_en) rd_cnt++;
            if (wb_valid) begin
                if (expq.size() == 0) begin
                    chk("wb_unexpected", 160'(wb_valid), 160'(0));
                end else begin
                    h = expq[0];
                    chk("wb_beat", {wb_addr, wb_chunk, wb_be, wb_data},
                        {h.addr, h.chunk, h.be, h.data});
                    if (wb_ready) begin
                        hs_be.push_back(wb_be);
                        hs_chunk.push_back(wb_chunk);
                        void'(expq.pop_front());
                        if (expq.size() == 0) exp_done = cyc + 1;
                    end
                end
            end
            if (req_valid && req_ready) begin
                n = build_model(req_type, req_vsew, int'(req_vl), int'(req_vs1),
                                int'(req_vs2), int'(req_vd));
                if (n == 0) exp_done = cyc + 1;
            end
        end
    end

    function automatic logic any_out();
        return |{rf_rd_en, rf_rd_addr1, rf_rd_addr2, rf_rd_chunk, su_ce, su_type, su_vsew,
                 su_vs1, su_vs2, wb_valid, wb_addr, wb_chunk, wb_data, wb_be, done};
    endfunction

    task automatic clear_logs();
        hs_be.delete();
        hs_chunk.delete();
        rd_cnt = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [2:0] sew, input logic [6:0] vl,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                         output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        @(posedge clk); #1;
        req_type = t; req_vsew = sew; req_vl = vl;
        req_vs1 = a1; req_vs2 = a2; req_vd = d; req_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; acc = cyc; end
        end
        if (!ok) chk("accept_timeout", 160'(req_ready), 160'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit ok;
        ok = 0;
        dc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; dc = cyc; end
        end
        if (!ok) chk("done_timeout", 160'(done), 160'(1));
    endtask

    task automatic wait_shift(input logic [1:0] c);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (su_ce && rf_rd_chunk == c) ok = 1;
        end
        if (!ok) chk("shift_timeout", 160'(su_ce), 160'(1));
    endtask

    initial begin
        int acc, dc, stable, rd_seen, acc_bad;
        logic [150:0] snap;
        rst_n = 1'b0; req_valid = 1'b0; req_type = '0; req_vsew = '0; req_vl = '0;
        req_vs1 = '0; req_vs2 = '0; req_vd = '0; wb_ready = 1'b1;
        snap = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 160'(req_ready), 160'(1));
        chk("reset_outs", 160'(any_out()), 160'(0));
        rst_n = 1'b1;

        // SLL, SEW8, vl=64: four full chunks
        clear_logs();
        issue(2'd1, 3'd0, 7'd64, 5'd1, 5'd2, 5'd3, acc);
        wait_done(dc);
        chk("t1_latency", 160'(dc - acc), 160'(17));
        chk("t1_beats", 160'(hs_be.size()), 160'(4));
        chk("t1_be", {hs_be[0], hs_be[1], hs_be[2], hs_be[3]}, 160'h0FFFF_FFFF_FFFF_FFFF);
        chk("t1_order", {hs_chunk[0], hs_chunk[1], hs_chunk[2], hs_chunk[3]}, 160'b00_01_10_11);

        // SRA, SEW16, vl=20: TB=40, partial last chunk
        clear_logs();
        issue(2'd3, 3'd1, 7'd20, 5'd4, 5'd5, 5'd6, acc);
        wait_done(dc);
        chk("t2_latency", 160'(dc - acc), 160'(13));
        chk("t2_beats", 160'(hs_be.size()), 160'(3));
        chk("t2_be", {hs_be[0], hs_be[1], hs_be[2]}, 160'hFFFF_FFFF_00FF);
        chk("t2_reads", 160'(rd_cnt), 160'(3));

        // vl=0 retires immediately
        clear_logs();
        issue(2'd1, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, acc);
        wait_done(dc);
        chk("t3_latency", 160'(dc - acc), 160'(1));
        chk("t3_quiet", {32'(rd_cnt), 32'(hs_be.size())}, 160'(0));

        // reserved SEW retires immediately
        clear_logs();
        issue(2'd2, 3'd5, 7'd10, 5'd1, 5'd2, 5'd3, acc);
        wait_done(dc);
        chk("t4_latency", 160'(dc - acc), 160'(1));
        chk("t4_quiet", {32'(rd_cnt), 32'(hs_be.size())}, 160'(0));

        // SRL, SEW32, vl=100 clamps to 16
        clear_logs();
        issue(2'd2, 3'd2, 7'd100, 5'd7, 5'd8, 5'd9, acc);
        wait_done(dc);
        chk("t5_latency", 160'(dc - acc), 160'(17));
        chk("t5_be", {32'(hs_be.size()), hs_be[0], hs_be[1], hs_be[2], hs_be[3]},
            {32'd4, 64'hFFFF_FFFF_FFFF_FFFF});

        // Backpressure on chunk 1 for 5 cycles
        clear_logs();
        issue(2'd1, 3'd3, 7'd8, 5'd10, 5'd11, 5'd12, acc);
        wait_shift(2'd1);
        wb_ready = 1'b0;
        stable = 0; rd_seen = 0; acc_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) snap = {wb_addr, wb_chunk, wb_be, wb_data};
            if (wb_valid && wb_chunk == 2'd1 && {wb_addr, wb_chunk, wb_be, wb_data} == snap)
                stable++;
            if (rf_rd_en) rd_seen = 1;
            if (req_valid && req_ready) acc_bad = 1;
            if (i == 1) begin
                req_type = 2'd1; req_vsew = 3'd0; req_vl = 7'd16; req_valid = 1'b1;
            end
            if (i == 3) req_valid = 1'b0;
            if (i == 5) wb_ready = 1'b1;
        end
        chk("t6_stable", 160'(stable), 160'(6));
        chk("t6_no_read", 160'(rd_seen), 160'(0));
        chk("t6_no_accept", 160'(acc_bad), 160'(0));
        wait_done(dc);
        chk("t6_latency", 160'(dc - acc), 160'(22));

        // Reset during SHIFT of chunk 2, then a fresh one-chunk request
        clear_logs();
        issue(2'd1, 3'd0, 7'd64, 5'd13, 5'd14, 5'd15, acc);
        wait_shift(2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_abort_ready", 160'(req_ready), 160'(1));
        chk("t7_abort_outs", 160'(any_out()), 160'(0));
        @(posedge clk); @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t7_no_done", 160'(hs_be.size()), 160'(2));
        clear_logs();
        issue(2'd1, 3'd0, 7'd16, 5'd16, 5'd17, 5'd18, acc);
        wait_done(dc);
        chk("t7_latency", 160'(dc - acc), 160'(5));
        chk("t7_be", {32'(hs_be.size()), hs_be[0]}, {32'd1, 16'hFFFF});

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule

// File: doc/vector_shift_sequencer.md
# vector_shift_sequencer

Multi-cycle issue controller for the combinational vector shift unit in the integer functional-unit cluster. It accepts one vector shift instruction at a time and reads vs1/vs2 from the vector register file in 128-bit chunks. It drives the shift unit's control and operand inputs, captures its result, and writes each chunk back with byte enables derived from vl and vsew. It is the initiator side of the shift unit's operand/result interface.

## Interface
- VLEN, 512: bits per vector register; must be a multiple of 128.
- NCHUNK, VLEN/128: chunks per register (derived); chunk index width CW = clog2(NCHUNK), minimum 1.
- clk_i  input  1  clock; all state updates on rising edge.
- rsn_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  instruction request valid.
- req_ready_o  output  1  sequencer idle, request accepted when valid & ready.
- req_shift_type_i  input  2  01 SLL, 10 SRL, 11 SRA, 00 none (result zero).
- req_vsew_i  input  3  SEW = 8<<vsew; values 4-7 reserved.
- req_vl_i  input  clog2(VLEN/8)+1  element count.
- req_vs1_addr_i, req_vs2_addr_i, req_vd_addr_i  input  5 each  register indices.
- rf_rd_en_o  output  1  register-file read strobe.
- rf_rd_addr1_o, rf_rd_addr2_o  output  5 each  read addresses (vs1, vs2).
- rf_rd_chunk_o  output  CW  chunk index being read.
- rf_rd_data1_i, rf_rd_data2_i  input  128 each  read data, valid the cycle after rf_rd_en_o.
- su_chip_enable_o  output  1  shift unit enable.
- su_shift_type_o  output  2; su_vsew_o  output  3  latched instruction fields.
- su_vs1_o, su_vs2_o  output  128 each  operand registers.
- su_vd_i  input  128  shift unit result (combinational from su_* outputs).
- wb_valid_o  output  1; wb_ready_i  input  1  writeback handshake.
- wb_addr_o  output  5; wb_chunk_o  output  CW; wb_data_o  output  128; wb_be_o  output  16.
- done_o  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, LATCH, SHIFT, WB.
- IDLE: req_ready_o=1. On accept, latch all req fields, chunk counter k=0. Clamp vl to VLMAX=VLEN/SEW. Compute total bytes TB = vl_clamped<<vsew and last chunk L = ceil(TB/16)-1.
- Accept with vl=0 or vsew>3: no reads or writes; done_o=1 the next cycle; stay IDLE.
- READ (1 cycle): rf_rd_en_o=1, addresses = latched vs1/vs2, rf_rd_chunk_o=k. Next state is LATCH.
- LATCH (1 cycle): capture rf_rd_data1_i/2_i into su_vs1_o/su_vs2_o. Next state is SHIFT.
- SHIFT (1 cycle): su_chip_enable_o=1; capture su_vd_i into wb_data_o. Compute wb_be_o bit b = (16k+b < TB). Next state is WB.
- WB: wb_valid_o=1; wb_addr_o=vd, wb_chunk_o=k; data, be, addr and chunk stay stable until wb_ready_i. On handshake: if k==L, go to IDLE and pulse done_o that cycle+1. Otherwise k=k+1 and go to READ.
- su_chip_enable_o=0 in every state except SHIFT. su_vs1_o/su_vs2_o hold their last value otherwise.
- req_valid_i while not IDLE is ignored (ready=0). wb_ready_i without wb_valid_o has no effect.

## Timing
- Reset values: state IDLE, req_ready_o=1. All other outputs 0, including operand, data and be registers and counters.
- Reset asserted mid-instruction: immediate abort to IDLE with outputs at reset values. No done_o and no partial writeback completion.
- Per-chunk minimum is 4 cycles (READ, LATCH, SHIFT, WB with ready high). An instruction of N chunks takes 4N cycles from accept+1 to final handshake. done_o rises in the cycle after the final handshake, together with req_ready_o=1.
- A new request can be accepted in the same cycle done_o is high.
- Backpressure: each cycle of wb_ready_i low extends WB by one cycle. No read for the next chunk is issued during WB.
- Chunks are written in ascending order 0..L. At most one outstanding read.

## Test plan
- SLL, vsew=0, vl=64, VLEN=512 -> 4 chunks, wb_chunk 0..3, every wb_be_o=FFFF. wb_data equals the shift unit result per chunk. done_o at accept+17.
- SRA, vsew=1, vl=20 (TB=40) -> 3 chunks, be FFFF, FFFF, 00FF. No 4th READ.
- vl=0 and separately vsew=5 -> done_o pulse at accept+1; rf_rd_en_o and wb_valid_o never asserted.
- SRL, vsew=2, vl=100 -> clamped to 16, TB=64, 4 chunks all FFFF.
- Hold wb_ready_i low 5 cycles on chunk 1 -> wb_* stable for 6 cycles, rf_rd_en_o stays 0. req_valid_i pulsed during this time is not accepted.
- Assert rsn_i low during SHIFT of chunk 2 -> all outputs 0 immediately, no done_o. After release, req_ready_o=1 and a fresh vl=16 vsew=0 request completes in 1 chunk with be=FFFF.
